div_cfg_ctrl: RTL and testbench

DIV_CFG_CTRL -- requirements
Module: div_cfg_ctrl

---
 rtl/div_cfg_ctrl_pkg.sv | 18 +
 rtl/div_cfg_ctrl_byte_timeout.sv | 35 +++
 rtl/div_cfg_ctrl.sv | 138 +++++++++++++
 tb/tb_div_cfg_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_cfg_ctrl_pkg.sv
// div_cfg_ctrl shared types and constants.
// State encoding, response bytes and default header byte.
package div_cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LO,
        ST_GET_HI,
        ST_CHECK,
        ST_WAIT_EDGE,
        ST_SEND
    } state_e;

    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/div_cfg_ctrl_byte_timeout.sv
// Inter-byte gap counter for the command receiver.
// Flags expiry after LIMIT cycles without a clear.
module div_cfg_ctrl_byte_timeout #(
    parameter logic [23:0] LIMIT = 24'd1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    // Count idle cycles while waiting on a payload byte.
    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end
    end

    // Gap counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q >= (LIMIT - 24'd1));

endmodule

// File: rtl/div_cfg_ctrl.sv
// UART-driven divider factor update controller.
// Receives HEADER+LO+HI, validates, applies on divider edge.
module div_cfg_ctrl
    import div_cfg_ctrl_pkg::*;
#(
    parameter logic [15:0] DEFAULT_FACTOR = 16'd1000,
    parameter logic [15:0] MIN_FACTOR     = 16'd2,
    parameter logic [7:0]  HEADER         = HEADER_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        clk_div_i,
    output logic [15:0] factor_o,
    output logic        upd_done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    state_e      state_q, state_d;
    logic [15:0] cand_q, cand_d;
    logic [15:0] factor_q, factor_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        upd_q, upd_d;
    logic        div_prev_q;
    logic        err;
    logic        gap_en;
    logic        gap_exp;
    logic        div_rise;

    assign gap_en   = (state_q == ST_GET_LO) ||
                      (state_q == ST_GET_HI);
    assign div_rise = clk_div_i && !div_prev_q;

    div_cfg_ctrl_byte_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (gap_en),
        .clr_i     (rx_valid_i),
        .expired_o (gap_exp)
    );

    // Next-state and command decode; err is a same-cycle pulse.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        factor_d  = factor_q;
        tx_data_d = tx_data_q;
        upd_d     = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && (rx_data_i == HEADER)) begin
                    state_d = ST_GET_LO;
                end
            end
            ST_GET_LO: begin
                if (rx_valid_i) begin
                    cand_d[7:0] = rx_data_i;
                    state_d     = ST_GET_HI;
                end else if (gap_exp) begin
                    err       = 1'b1;
                    tx_data_d = NAK_BYTE;
                    state_d   = ST_SEND;
                end
            end
            ST_GET_HI: begin
                if (rx_valid_i) begin
                    cand_d[15:8] = rx_data_i;
                    state_d      = ST_CHECK;
                end else if (gap_exp) begin
                    err       = 1'b1;
                    tx_data_d = NAK_BYTE;
                    state_d   = ST_SEND;
                end
            end
            ST_CHECK: begin
                if (cand_q >= MIN_FACTOR) begin
                    state_d = ST_WAIT_EDGE;
                end else begin
                    err       = 1'b1;
                    tx_data_d = NAK_BYTE;
                    state_d   = ST_SEND;
                end
            end
            ST_WAIT_EDGE: begin
                if (div_rise) begin
                    factor_d  = cand_q;
                    upd_d     = 1'b1;
                    tx_data_d = ACK_BYTE;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, candidate, factor and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            factor_q   <= DEFAULT_FACTOR;
            tx_data_q  <= '0;
            upd_q      <= 1'b0;
            div_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            factor_q   <= factor_d;
            tx_data_q  <= tx_data_d;
            upd_q      <= upd_d;
            div_prev_q <= clk_div_i;
        end
    end

    assign factor_o   = factor_q;
    assign upd_done_o = upd_q;
    assign err_o      = err;
    assign busy_o     = (state_q != ST_IDLE);
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = (state_q == ST_SEND);

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Directed self-checking bench for div_cfg_ctrl.
// Short timeout override keeps the gap test fast.
module tb_div_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        clk_div;
    logic [15:0] factor;
    logic        upd_done;
    logic        err;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_assert = 0;
    int n_fail   = 0;

    div_cfg_ctrl #(
        .TIMEOUT_CYCLES (24'd20)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .clk_div_i  (clk_div),
        .factor_o   (factor),
        .upd_done_o (upd_done),
        .err_o      (err),
        .busy_o     (busy),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic accept();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    int  err_at;
    int  err_cnt;
    logic stable;

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        clk_div  = 1'b0;
        tx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_factor", 32'(factor), 32'd1000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_txv", 32'(tx_valid), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);
        check("rst_upd", 32'(upd_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // factor below minimum -> NAK
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        check("min_err_chk", 32'(err), 32'd1);
        check("min_busy", 32'(busy), 32'd1);
        tick();
        check("min_err_off", 32'(err), 32'd0);
        check("min_txv", 32'(tx_valid), 32'd1);
        check("min_nak", 32'(tx_data), 32'h15);
        check("min_factor", 32'(factor), 32'd1000);
        accept();
        check("min_idle", 32'(busy), 32'd0);
        check("min_txv_off", 32'(tx_valid), 32'd0);

        // normal update 0x1234
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        tick();
        tick();
        send_byte(8'h99);
        tick();
        check("we_busy", 32'(busy), 32'd1);
        check("we_factor", 32'(factor), 32'd1000);
        check("we_txv", 32'(tx_valid), 32'd0);
        clk_div = 1'b1;
        tick();
        check("upd_factor", 32'(factor), 32'h1234);
        check("upd_pulse", 32'(upd_done), 32'd1);
        check("upd_noerr", 32'(err), 32'd0);
        check("upd_txv", 32'(tx_valid), 32'd1);
        check("upd_ack", 32'(tx_data), 32'h06);
        tick();
        check("upd_pulse_off", 32'(upd_done), 32'd0);
        clk_div = 1'b0;

        // hold tx_ready low in SEND
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h06)
                stable = 1'b0;
            tick();
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_txv", 32'(tx_valid), 32'd1);
        accept();
        check("hold_idle", 32'(busy), 32'd0);
        check("hold_txv_off", 32'(tx_valid), 32'd0);

        // inter-byte timeout in GET_HI
        send_byte(8'hA5);
        send_byte(8'h34);
        err_at  = 0;
        err_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (err) begin
                err_cnt++;
                if (err_at == 0) err_at = k - 1;
            end
            tick();
        end
        check("to_err_at", 32'(err_at), 32'd19);
        check("to_err_once", 32'(err_cnt), 32'd1);
        check("to_txv", 32'(tx_valid), 32'd1);
        check("to_nak", 32'(tx_data), 32'h15);
        check("to_factor", 32'(factor), 32'h1234);
        accept();
        check("to_idle", 32'(busy), 32'd0);

        // stray bytes, header as payload
        send_byte(8'h00);
        check("stray0_busy", 32'(busy), 32'd0);
        send_byte(8'hFF);
        check("strayff_busy", 32'(busy), 32'd0);
        check("stray_txv", 32'(tx_valid), 32'd0);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h00);
        tick();
        clk_div = 1'b1;
        tick();
        clk_div = 1'b0;
        check("hdr_factor", 32'(factor), 32'h00A5);
        check("hdr_ack", 32'(tx_data), 32'h06);
        accept();

        // reset in WAIT_EDGE aborts
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        tick();
        rst     = 1'b1;
        clk_div = 1'b1;
        tick();
        rst     = 1'b0;
        clk_div = 1'b0;
        tick();
        check("abort_factor", 32'(factor), 32'd1000);
        check("abort_txv", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_upd", 32'(upd_done), 32'd0);

        // next command after abort
        send_byte(8'hA5);
        send_byte(8'h78);
        send_byte(8'h56);
        tick();
        clk_div = 1'b1;
        tick();
        clk_div = 1'b0;
        check("post_factor", 32'(factor), 32'h5678);
        check("post_upd", 32'(upd_done), 32'd1);
        check("post_ack", 32'(tx_data), 32'h06);
        accept();
        check("post_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
